fanin_rr_arbiter: RTL and testbench
===================================

# fanin_rr_arbiter

Round-robin arbiter that shares a single 8-to-1 fan-in datapath among eight requesters. Each cycle it selects at most one requesting input, captures that input's data word into a one-entry output register, and presents it on a valid/ready output port. It sits in front of the two-input reduction tree and sequences which source drives the tree's single output, guaranteeing fair, starvation-free access.

## Interface
- DATA_W, 8, width of each requester's data word and of y_data.
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-high.
- req  input  8  per-requester request; bit i = requester i has a word on data_in slice i.
- data_in  input  8*DATA_W  packed words; requester i occupies bits [i*DATA_W +: DATA_W].
- gnt  output  8  one-hot acceptance strobe; gnt[i]=1 in the cycle requester i's word is captured; combinational from req, ptr and output-register state.
- y_valid  output  1  output register holds a word.
- y_ready  input  1  downstream accepts the word when y_valid && y_ready.
- y_data  output  DATA_W  captured word.
- y_src  output  3  index of the requester that supplied y_data.

## Operation
- State: output register {y_valid, y_data, y_src}; rotating priority pointer ptr[2:0].
- Reset values: y_valid=0, y_data=0, y_src=0, ptr=0; gnt=0 while rst is high.
- can_load = !y_valid || y_ready.
- Selection: when can_load and req!=0, winner = first i with req[i]=1, scanning ptr, ptr+1, ..., ptr+7 (mod 8). Exactly one gnt bit is high; all others are 0.
- On a grant to i: y_data <= data_in slice i, y_src <= i, y_valid <= 1, ptr <= (i+1) mod 8.
- Output drain without a new grant (y_valid && y_ready, and req==0): y_valid <= 0; y_data and y_src hold their last values.
- Output stall (y_valid && !y_ready): no grant, gnt=0, register and ptr hold.
- ptr changes only on a grant; idle cycles leave it unchanged.
- Requesters hold req and data stable until they see gnt. A requester that deasserts req before its grant is simply skipped, with no error.
- A requester may keep req high after its grant to offer its next word. It is then lowest priority until the other active requesters have been served.

## Timing
- Grant-to-output latency: 1 cycle. Word granted in cycle N appears with y_valid=1 in cycle N+1.
- Throughput: 1 word/cycle with y_ready held high. Drain and reload happen in the same cycle, with no bubble.
- Fairness: with all 8 requesting continuously and y_ready=1, grants rotate in strict order; any requester waits at most 7 grants.
- Simultaneous events:
  - Drain plus new grant in one cycle: the new word replaces the old one and y_valid stays 1.
  - Grant to the requester at ptr: ptr advances to ptr+1.
- Wrap-around: after a grant to requester 7, ptr becomes 0.
- Reset mid-operation: any word held in the output register is discarded. All outputs return to their reset values asynchronously. The first grant after release of rst is evaluated from ptr=0.
- No combinational path from y_ready to y_data. A combinational path from y_ready to gnt is permitted.

## Test plan
- Reset check: assert rst mid-transfer with y_valid=1 -> y_valid=0, y_data=0, y_src=0 and gnt=0 immediately. After release, req=8'hFF -> first grant is gnt=8'h01.
- Full rotation: req=8'hFF held, y_ready=1, data_in slice i = 8'hA0+i -> gnt walks 01,02,04,...,80,01. y_src sequence is 0..7,0 and y_data follows one cycle later (A0..A7).
- Sparse pointer skip: after a grant to 2, req=8'b1000_0010 -> next grant goes to 7 (gnt=8'h80), then to 1; ptr wraps to 0 after the grant to 7.
- Back-pressure: req=8'h0C, y_ready=0 for 4 cycles after the first grant -> y_valid=1 with y_src=2 held, gnt=0 throughout. When y_ready=1, requester 3 is granted in the same cycle, with no bubble.
- Drain to idle: single grant to 5, then req=0, y_ready=1 -> y_valid falls the next cycle, y_data keeps its last value, and ptr stays at 6.
- Random stress: random req/y_ready over 10k cycles -> scoreboard confirms one-hot gnt, no lost or duplicated words, and a wait of at most 7 grants per requester.

Source files
------------

// File: rtl/fanin_rr_arbiter.sv
// Round-robin arbiter feeding one of eight requesters' words into a single
// valid/ready output register; the rotating pointer guarantees fair access.
module fanin_rr_arbiter #(
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          req,
    input  logic [8*DATA_W-1:0] data_in,
    output logic [7:0]          gnt,
    output logic                y_valid,
    input  logic                y_ready,
    output logic [DATA_W-1:0]   y_data,
    output logic [2:0]          y_src
);

    logic              y_valid_q, y_valid_d;
    logic [DATA_W-1:0] y_data_q, y_data_d;
    logic [2:0]        y_src_q, y_src_d;
    logic [2:0]        ptr_q, ptr_d;

    logic              can_load;
    logic              win_found;
    logic [2:0]        win_idx;
    logic [2:0]        scan_idx;

    // Scan from ptr upwards (mod 8); the first requester seen wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            scan_idx = ptr_q + 3'(k);
            if (!win_found && req[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        can_load  = !y_valid_q || y_ready;
        gnt       = '0;
        y_valid_d = y_valid_q;
        y_data_d  = y_data_q;
        y_src_d   = y_src_q;
        ptr_d     = ptr_q;
        if (!rst && can_load && win_found) begin
            gnt[win_idx] = 1'b1;
            y_valid_d    = 1'b1;
            y_data_d     = data_in[win_idx*DATA_W +: DATA_W];
            y_src_d      = win_idx;
            ptr_d        = win_idx + 3'd1;
        end else if (y_valid_q && y_ready) begin
            y_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_valid_q <= 1'b0;
            y_data_q  <= '0;
            y_src_q   <= '0;
            ptr_q     <= '0;
        end else begin
            y_valid_q <= y_valid_d;
            y_data_q  <= y_data_d;
            y_src_q   <= y_src_d;
            ptr_q     <= ptr_d;
        end
    end

    assign y_valid = y_valid_q;
    assign y_data  = y_data_q;
    assign y_src   = y_src_q;

endmodule

// File: tb/tb_fanin_rr_arbiter.sv
// Bench for fanin_rr_arbiter: directed scenarios plus randomized traffic
// compared against a service-order queue model.
module tb_fanin_rr_arbiter;

    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [7:0]      req = '0;
    logic [8*DW-1:0] data_in = '0;
    logic [7:0]      gnt;
    logic            y_valid;
    logic            y_ready = 1'b1;
    logic [DW-1:0]   y_data;
    logic [2:0]      y_src;

    int tests_run = 0;
    int tests_failed = 0;

    fanin_rr_arbiter #(.DATA_W(DW)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .data_in (data_in),
        .gnt     (gnt),
        .y_valid (y_valid),
        .y_ready (y_ready),
        .y_data  (y_data),
        .y_src   (y_src)
    );

    always #5 clk = ~clk;

    // Model: service order is a queue of requester ids; a served id and all
    // ids it overtook move to the back, so the queue front is the next in turn.
    int            order[$];
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic [2:0]    m_src;

    task automatic model_reset();
        order.delete();
        for (int i = 0; i < 8; i++) order.push_back(i);
        m_valid = 1'b0;
        m_data  = '0;
        m_src   = '0;
    endtask

    function automatic int model_pick(logic [7:0] r);
        foreach (order[k]) if (r[order[k]]) return order[k];
        return -1;
    endfunction

    task automatic model_serve(int w);
        for (int n = 0; n < 8; n++) begin
            int h;
            h = order.pop_front();
            order.push_back(h);
            if (h == w) break;
        end
    endtask

    // One clock: sample gnt mid-cycle, predict it, clock, advance the model.
    task automatic tick(output logic [7:0] g_obs, output logic [7:0] g_exp, output int w);
        #2;
        w = model_pick(req);
        g_exp = '0;
        if (!rst && (!m_valid || y_ready) && w >= 0) g_exp[w] = 1'b1;
        g_obs = gnt;
        @(posedge clk);
        if (rst) model_reset();
        else if (g_exp != 0) begin
            m_valid = 1'b1;
            m_data  = data_in[w*DW +: DW];
            m_src   = 3'(w);
            model_serve(w);
        end else if (m_valid && y_ready) m_valid = 1'b0;
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic set_default_data();
        for (int i = 0; i < 8; i++) data_in[i*DW +: DW] = 8'hA0 + 8'(i);
    endtask

    task automatic test_reset();
        logic [7:0] go, ge;
        int w;
        req = 8'hFF; y_ready = 1'b1;
        set_default_data();
        model_reset();
        #3;
        tests_run++;
        if (gnt !== 8'h00 || y_valid !== 1'b0 || y_data !== '0 || y_src !== 3'd0) begin
            tests_failed++;
            $display("FAIL reset_init: gnt=%h v=%b d=%h s=%0d required 00/0/00/0", gnt, y_valid, y_data, y_src);
        end
        @(posedge clk); #1; rst = 1'b0;
        tick(go, ge, w);
        tests_run++;
        if (go !== 8'h01) begin
            tests_failed++;
            $display("FAIL reset_first_grant: gnt=%h required 01", go);
        end
        tests_run++;
        if (y_valid !== 1'b1 || y_data !== 8'hA0 || y_src !== 3'd0) begin
            tests_failed++;
            $display("FAIL reset_load: v=%b d=%h s=%0d required 1/a0/0", y_valid, y_data, y_src);
        end
        tick(go, ge, w);
        rst = 1'b1;
        #1;
        tests_run++;
        if (gnt !== 8'h00 || y_valid !== 1'b0 || y_data !== '0 || y_src !== 3'd0) begin
            tests_failed++;
            $display("FAIL reset_mid: gnt=%h v=%b d=%h s=%0d required 00/0/00/0", gnt, y_valid, y_data, y_src);
        end
        model_reset();
        @(posedge clk); #1; rst = 1'b0;
        tick(go, ge, w);
        tests_run++;
        if (go !== 8'h01) begin
            tests_failed++;
            $display("FAIL reset_release_grant: gnt=%h required 01", go);
        end
    endtask

    task automatic test_full_rotation();
        logic [7:0] go, ge, one;
        int w;
        apply_reset();
        set_default_data();
        req = 8'hFF; y_ready = 1'b1;
        one = 8'h01;
        for (int k = 0; k < 9; k++) begin
            tick(go, ge, w);
            tests_run++;
            if (go !== (one << (k % 8))) begin
                tests_failed++;
                $display("FAIL rotation_gnt[%0d]: gnt=%h required %h", k, go, one << (k % 8));
            end
            tests_run++;
            if (y_valid !== 1'b1 || y_src !== 3'(k % 8) || y_data !== 8'hA0 + 8'(k % 8)) begin
                tests_failed++;
                $display("FAIL rotation_out[%0d]: v=%b s=%0d d=%h required 1/%0d/%h",
                         k, y_valid, y_src, y_data, k % 8, 8'hA0 + 8'(k % 8));
            end
        end
    endtask

    task automatic test_sparse_skip();
        logic [7:0] go, ge;
        int w;
        apply_reset();
        set_default_data();
        y_ready = 1'b1;
        req = 8'h04;
        tick(go, ge, w);
        req = 8'b1000_0010;
        tick(go, ge, w);
        tests_run++;
        if (go !== 8'h80) begin
            tests_failed++;
            $display("FAIL sparse_to_7: gnt=%h required 80", go);
        end
        tick(go, ge, w);
        tests_run++;
        if (go !== 8'h02 || y_src !== 3'd1 || y_data !== 8'hA1) begin
            tests_failed++;
            $display("FAIL sparse_wrap_to_1: gnt=%h s=%0d d=%h required 02/1/a1", go, y_src, y_data);
        end
    endtask

    task automatic test_back_pressure();
        logic [7:0] go, ge;
        int w;
        apply_reset();
        set_default_data();
        req = 8'h0C; y_ready = 1'b1;
        tick(go, ge, w);
        tests_run++;
        if (go !== 8'h04) begin
            tests_failed++;
            $display("FAIL bp_first: gnt=%h required 04", go);
        end
        y_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick(go, ge, w);
            tests_run++;
            if (go !== 8'h00 || y_valid !== 1'b1 || y_src !== 3'd2 || y_data !== 8'hA2) begin
                tests_failed++;
                $display("FAIL bp_stall[%0d]: gnt=%h v=%b s=%0d d=%h required 00/1/2/a2", k, go, y_valid, y_src, y_data);
            end
        end
        y_ready = 1'b1;
        tick(go, ge, w);
        tests_run++;
        if (go !== 8'h08 || y_valid !== 1'b1 || y_src !== 3'd3 || y_data !== 8'hA3) begin
            tests_failed++;
            $display("FAIL bp_release: gnt=%h v=%b s=%0d d=%h required 08/1/3/a3", go, y_valid, y_src, y_data);
        end
    endtask

    task automatic test_drain_idle();
        logic [7:0] go, ge;
        int w;
        apply_reset();
        set_default_data();
        y_ready = 1'b1;
        req = 8'h20;
        tick(go, ge, w);
        req = 8'h00;
        tick(go, ge, w);
        tests_run++;
        if (go !== 8'h00 || y_valid !== 1'b0 || y_data !== 8'hA5 || y_src !== 3'd5) begin
            tests_failed++;
            $display("FAIL drain: gnt=%h v=%b d=%h s=%0d required 00/0/a5/5", go, y_valid, y_data, y_src);
        end
        tick(go, ge, w);
        req = 8'hFF;
        tick(go, ge, w);
        tests_run++;
        if (go !== 8'h40) begin
            tests_failed++;
            $display("FAIL drain_ptr_held: gnt=%h required 40", go);
        end
    endtask

    task automatic test_random();
        logic [7:0]    go, ge;
        int            w;
        logic [10:0]   sb[$];
        logic [10:0]   head;
        int            waits[8];
        apply_reset();
        foreach (waits[i]) waits[i] = 0;
        req = '0;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < 8; i++) if (!req[i] || c == 0) data_in[i*DW +: DW] = 8'($urandom);
            y_ready = ($urandom_range(3) != 0);
            #2;
            if (y_valid && y_ready) begin
                tests_run++;
                if (sb.size() == 0) begin
                    tests_failed++;
                    $display("FAIL rnd_extra_word: cycle %0d s=%0d d=%h required none", c, y_src, y_data);
                end else begin
                    head = sb.pop_front();
                    if ({y_src, y_data} !== head) begin
                        tests_failed++;
                        $display("FAIL rnd_word: cycle %0d s=%0d d=%h required %0d/%h", c, y_src, y_data, head[10:8], head[7:0]);
                    end
                end
            end
            #(-2 + 2);
            // tick re-waits its own settle; inputs are unchanged meanwhile
            tick(go, ge, w);
            tests_run++;
            if (go !== ge || $countones(go) > 1) begin
                tests_failed++;
                $display("FAIL rnd_gnt: cycle %0d gnt=%h required %h", c, go, ge);
            end
            tests_run++;
            if (y_valid !== m_valid || (m_valid && (y_data !== m_data || y_src !== m_src))) begin
                tests_failed++;
                $display("FAIL rnd_out: cycle %0d v=%b d=%h s=%0d required %b/%h/%0d", c, y_valid, y_data, y_src, m_valid, m_data, m_src);
            end
            if (ge != 0) begin
                sb.push_back({3'(w), data_in[w*DW +: DW]});
                tests_run++;
                if (waits[w] > 7) begin
                    tests_failed++;
                    $display("FAIL rnd_fairness: requester %0d waited %0d grants required <=7", w, waits[w]);
                end
                for (int i = 0; i < 8; i++) begin
                    if (i == w) waits[i] = 0;
                    else if (req[i]) waits[i]++;
                end
            end
            for (int i = 0; i < 8; i++) begin
                if (ge[i]) req[i] = ($urandom_range(1) == 1);
                else if (!req[i]) req[i] = ($urandom_range(3) == 0);
                else if ($urandom_range(31) == 0) req[i] = 1'b0;
                if (!req[i]) waits[i] = 0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_rotation();
        test_sparse_skip();
        test_back_pressure();
        test_drain_idle();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
